gwa_payout_sched: RTL and testbench

Credit and payout scheduler for the drink vending machine (GW-Automat).
- Accepts 1- and 2-unit coins and accumulates credit.
- On the select key, vends one drink at a fixed price.
- Returns any change, or the full credit on cancel, through a single shared coin ejector. The ejector takes one coin per valid/ready handshake.
- Sits between the coin/key front end and the ejector mechanism. It serialises all ejector requests.

---
 rtl/gwa_payout_sched_if.sv | 16 +
 rtl/gwa_payout_sched.sv | 82 ++++++++
 tb/tb_gwa_payout_sched.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/gwa_payout_sched_if.sv
// gwa_payout_sched_if: coin/key front end and ejector signals of the payout scheduler
interface gwa_payout_sched_if #(parameter int CREDIT_W = 4);
  logic EU1;
  logic EU2;
  logic WT;
  logic CANCEL;
  logic ej_rdy;
  logic EU1_O;
  logic EU2_O;
  logic VEND_O;
  logic REJ_O;
  logic busy_o;
  logic [CREDIT_W-1:0] credit_o;
  modport master (output EU1, EU2, WT, CANCEL, ej_rdy, input EU1_O, EU2_O, VEND_O, REJ_O, busy_o, credit_o);
  modport slave (input EU1, EU2, WT, CANCEL, ej_rdy, output EU1_O, EU2_O, VEND_O, REJ_O, busy_o, credit_o);
endinterface

// File: rtl/gwa_payout_sched.sv
// gwa_payout_sched: credit accumulation, vend and greedy coin payout through one ejector
module gwa_payout_sched #(
  parameter int CREDIT_W   = 4,
  parameter int PRICE      = 3,
  parameter int MAX_CREDIT = 9
) (
  input logic clk,
  input logic rst,
  gwa_payout_sched_if.slave bus
);
  typedef enum logic [1:0] {IDLE, VEND, PAYOUT} state_t;
  localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);
  localparam logic [CREDIT_W:0] MAX_C = (CREDIT_W+1)'(MAX_CREDIT);
  state_t state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d, pay;
  logic [CREDIT_W:0] sum;
  logic [3:0] smp_q, prv_q, rise;
  logic [1:0] coin;
  logic vend_q, vend_d, rej_q, rej_d, coin_in, wt_ok, can_ok;
  always_comb begin
    rise = smp_q & ~prv_q;
    coin = rise[1:0];
    coin_in = |coin;
    sum = {1'b0, credit_q} + (CREDIT_W+1)'(coin);
    wt_ok = rise[2] && credit_q >= PRICE_C;
    can_ok = rise[3] && credit_q != '0;
    pay = bus.EU2_O ? CREDIT_W'(2) : CREDIT_W'(1);
    state_d = state_q;
    credit_d = credit_q;
    vend_d = 1'b0;
    rej_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (wt_ok) begin
          state_d = VEND;
          credit_d = credit_q - PRICE_C;
          vend_d = 1'b1;
          rej_d = coin_in;
        end else if (can_ok) begin
          state_d = PAYOUT;
          rej_d = coin_in;
        end else if (coin_in) begin
          credit_d = sum <= MAX_C ? sum[CREDIT_W-1:0] : credit_q;
          rej_d = sum > MAX_C;
        end
      end
      VEND: begin
        state_d = credit_q != '0 ? PAYOUT : IDLE;
        rej_d = coin_in;
      end
      PAYOUT: begin
        rej_d = coin_in;
        credit_d = bus.ej_rdy ? credit_q - pay : credit_q;
        state_d = bus.ej_rdy && credit_q == pay ? IDLE : PAYOUT;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      credit_q <= '0;
      vend_q <= 1'b0;
      rej_q <= 1'b0;
      smp_q <= '0;
      prv_q <= '0;
    end else begin
      state_q <= state_d;
      credit_q <= credit_d;
      vend_q <= vend_d;
      rej_q <= rej_d;
      smp_q <= {bus.CANCEL, bus.WT, bus.EU2, bus.EU1};
      prv_q <= smp_q;
    end
  end
  assign bus.EU2_O = state_q == PAYOUT && credit_q >= CREDIT_W'(2);
  assign bus.EU1_O = state_q == PAYOUT && credit_q == CREDIT_W'(1);
  assign bus.VEND_O = vend_q;
  assign bus.REJ_O = rej_q;
  assign bus.credit_o = credit_q;
  assign bus.busy_o = state_q != IDLE;
endmodule

// File: tb/tb_gwa_payout_sched.sv
// tb_gwa_payout_sched: directed and random stimulus checked against a credit/payout model
module tb_gwa_payout_sched;
  localparam int PRICE = 3;
  localparam int MAXC = 9;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  int m_credit = 0, accepted = 0, vends = 0, paid = 0;
  bit vending = 0, paying = 0, m_vend = 0, m_rej = 0, m_rst = 0, started = 0;
  logic [3:0] h1 = '0, h2 = '0, rise;
  int coin;
  gwa_payout_sched_if #(.CREDIT_W(4)) bus ();
  gwa_payout_sched #(.CREDIT_W(4), .PRICE(PRICE), .MAX_CREDIT(MAXC)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string n, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", n, got, exp, $time);
    end
  endtask
  task automatic drive(input logic [3:0] m);
    {bus.CANCEL, bus.WT, bus.EU2, bus.EU1} = m;
  endtask
  task automatic wait_c(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask
  task automatic press(input logic [3:0] m);
    drive(m);
    wait_c(1);
    drive(4'b0);
    wait_c(1);
  endtask
  initial begin
    forever begin
      @(negedge clk);
      if (started) begin
        if (m_rst) begin
          vends = 0;
          paid = 0;
        end
        chk("vend", bus.VEND_O, m_vend);
        chk("rej", bus.REJ_O, m_rej);
        chk("eu2_req", bus.EU2_O, paying && m_credit >= 2);
        chk("eu1_req", bus.EU1_O, paying && m_credit == 1);
        chk("credit", int'(bus.credit_o), m_credit);
        chk("busy", bus.busy_o, vending || paying);
        chk("req_excl", bus.EU1_O & bus.EU2_O, 0);
        vends += bus.VEND_O;
        chk("conserve", accepted, PRICE * vends + paid + int'(bus.credit_o));
        if (bus.ej_rdy) paid += bus.EU2_O ? 2 : bus.EU1_O ? 1 : 0;
      end
      m_vend = 0;
      m_rej = 0;
      if (rst) begin
        m_credit = 0;
        accepted = 0;
        vending = 0;
        paying = 0;
        h1 = '0;
        h2 = '0;
        m_rst = 1;
        started = 1;
      end else begin
        m_rst = 0;
        rise = h1 & ~h2;
        coin = rise[0] + 2 * rise[1];
        if (paying) begin
          m_rej = coin != 0;
          if (bus.ej_rdy) m_credit -= (m_credit >= 2) ? 2 : 1;
          if (m_credit == 0) paying = 0;
        end else if (vending) begin
          m_rej = coin != 0;
          vending = 0;
          paying = m_credit > 0;
        end else if (rise[2] && m_credit >= PRICE) begin
          m_credit -= PRICE;
          vending = 1;
          m_vend = 1;
          m_rej = coin != 0;
        end else if (rise[3] && m_credit > 0) begin
          paying = 1;
          m_rej = coin != 0;
        end else if (coin != 0) begin
          if (m_credit + coin <= MAXC) begin
            m_credit += coin;
            accepted += coin;
          end else m_rej = 1;
        end
        h2 = h1;
        h1 = {bus.CANCEL, bus.WT, bus.EU2, bus.EU1};
      end
    end
  end
  initial begin
    drive(4'b0);
    bus.ej_rdy = 1'b0;
    wait_c(2);
    rst = 1'b0;
    chk("rst_credit", int'(bus.credit_o), 0);
    chk("rst_busy", bus.busy_o, 0);
    chk("rst_outs", {bus.EU1_O, bus.EU2_O, bus.VEND_O, bus.REJ_O}, 0);
    bus.ej_rdy = 1'b1;
    press(4'b0001);
    chk("t1_credit1", int'(bus.credit_o), 1);
    press(4'b0010);
    chk("t1_credit3", int'(bus.credit_o), 3);
    press(4'b0100);
    chk("t1_credit0", int'(bus.credit_o), 0);
    chk("t1_vend", bus.VEND_O, 1);
    chk("t1_busy", bus.busy_o, 1);
    wait_c(1);
    chk("t1_vend_end", bus.VEND_O, 0);
    chk("t1_idle", bus.busy_o, 0);
    chk("t1_noreq", bus.EU1_O | bus.EU2_O, 0);
    press(4'b0010);
    press(4'b0010);
    chk("t2_credit4", int'(bus.credit_o), 4);
    press(4'b0100);
    chk("t2_credit1", int'(bus.credit_o), 1);
    chk("t2_vend", bus.VEND_O, 1);
    wait_c(1);
    chk("t2_eu1", bus.EU1_O, 1);
    chk("t2_eu2", bus.EU2_O, 0);
    wait_c(1);
    chk("t2_credit0", int'(bus.credit_o), 0);
    chk("t2_idle", bus.busy_o, 0);
    repeat (4) press(4'b0010);
    press(4'b0001);
    chk("t3_credit9", int'(bus.credit_o), 9);
    chk("t3_model9", m_credit, 9);
    press(4'b0001);
    chk("t3_rej", bus.REJ_O, 1);
    chk("t3_credit_kept", int'(bus.credit_o), 9);
    wait_c(1);
    chk("t3_rej_end", bus.REJ_O, 0);
    bus.ej_rdy = 1'b0;
    press(4'b1000);
    chk("t3_busy", bus.busy_o, 1);
    chk("t3_eu2", bus.EU2_O, 1);
    wait_c(3);
    chk("t3_eu2_held", bus.EU2_O, 1);
    chk("t3_credit_held", int'(bus.credit_o), 9);
    bus.ej_rdy = 1'b1;
    wait_c(1);
    chk("t3_credit7", int'(bus.credit_o), 7);
    wait_c(3);
    chk("t3_credit1", int'(bus.credit_o), 1);
    chk("t3_eu1", bus.EU1_O, 1);
    chk("t3_model1", m_credit, 1);
    wait_c(1);
    chk("t3_credit0", int'(bus.credit_o), 0);
    chk("t3_idle", bus.busy_o, 0);
    press(4'b0010);
    press(4'b0100);
    chk("t4_credit2", int'(bus.credit_o), 2);
    chk("t4_novend", bus.VEND_O, 0);
    chk("t4_idle", bus.busy_o, 0);
    drive(4'b0001);
    wait_c(4);
    chk("t4_credit3", int'(bus.credit_o), 3);
    drive(4'b0000);
    wait_c(2);
    chk("t4_once", int'(bus.credit_o), 3);
    bus.ej_rdy = 1'b0;
    press(4'b1000);
    chk("t5_eu2", bus.EU2_O, 1);
    press(4'b0110);
    chk("t5_rej", bus.REJ_O, 1);
    chk("t5_credit", int'(bus.credit_o), 3);
    chk("t5_eu2_kept", bus.EU2_O, 1);
    wait_c(1);
    chk("t5_rej_end", bus.REJ_O, 0);
    bus.ej_rdy = 1'b1;
    wait_c(1);
    chk("t5_credit1", int'(bus.credit_o), 1);
    chk("t5_eu1", bus.EU1_O, 1);
    bus.ej_rdy = 1'b0;
    rst = 1'b1;
    wait_c(1);
    rst = 1'b0;
    chk("t5_rst_credit", int'(bus.credit_o), 0);
    chk("t5_rst_busy", bus.busy_o, 0);
    chk("t5_rst_outs", {bus.EU1_O, bus.EU2_O, bus.VEND_O, bus.REJ_O}, 0);
    repeat (3000) begin
      bus.EU1 = $urandom_range(0, 3) == 0;
      bus.EU2 = $urandom_range(0, 3) == 0;
      bus.WT = $urandom_range(0, 5) == 0;
      bus.CANCEL = $urandom_range(0, 9) == 0;
      bus.ej_rdy = $urandom_range(0, 1) == 1;
      rst = $urandom_range(0, 399) == 0;
      wait_c(1);
    end
    drive(4'b0);
    rst = 1'b0;
    wait_c(3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
